// File: rtl/init_table_mac.sv
// init_table_mac: table-driven multiply-accumulate datapath with a
// post-reset table init sequencer, a run-time write port and a result pipe.
module init_table_mac #(
  parameter  int NBITS     = 8,
  parameter  int NROWS     = 4,
  parameter  int NCOLS     = 4,
  parameter  int K_B       = 3,
  parameter  int INIT_BASE = 0,
  parameter  int INIT_STEP = 1,
  parameter  int ACC_INIT  = 21,
  localparam int RW = (NROWS > 1) ? $clog2(NROWS) : 1,
  localparam int CW = (NCOLS > 1) ? $clog2(NCOLS) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WR_EN,
  input  logic [RW-1:0]    WR_ROW,
  input  logic [CW-1:0]    WR_COL,
  input  logic [NBITS-1:0] WR_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [NBITS-1:0] A,
  input  logic [NBITS-1:0] B,
  input  logic [RW-1:0]    ROW,
  input  logic [CW-1:0]    COL,
  input  logic             CLR_ACC,
  output logic             OUT_VALID,
  output logic [NBITS-1:0] XOUT,
  output logic [NBITS-1:0] ACC,
  output logic             BUSY
);

  localparam int NT = NROWS * NCOLS;
  localparam int IW = (NT > 1) ? $clog2(NT) : 1;
  localparam logic [NBITS-1:0] KB   = NBITS'(K_B);
  localparam logic [IW-1:0]    LAST = IW'(NT - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  logic [NBITS-1:0] tbl [NT];

  state_t           state_q;
  logic [IW-1:0]    cnt_q;
  logic             busy_q;
  logic             rdy_q;
  logic [NBITS-1:0] acc_q;
  logic [NBITS-1:0] acc_d;

  logic             v1_q;
  logic [NBITS-1:0] a1_q;
  logic [NBITS-1:0] b1_q;
  logic [NBITS-1:0] t1_q;
  logic [NBITS-1:0] n1_q;

  logic             v2_q;
  logic [NBITS-1:0] diff2_q;
  logic [NBITS-1:0] prod2_q;

  logic             ov_q;
  logic [NBITS-1:0] x_q;

  logic             acc_en;
  logic             rd_ok;
  logic             wr_ok;
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    wr_idx;
  logic [NBITS-1:0] t_rd;

  assign acc_en = IN_VALID && rdy_q;

  always_comb begin
    rd_ok  = (int'(ROW) < NROWS) && (int'(COL) < NCOLS);
    wr_ok  = (int'(WR_ROW) < NROWS) && (int'(WR_COL) < NCOLS);
    rd_idx = IW'(int'(ROW) * NCOLS + int'(COL));
    wr_idx = IW'(int'(WR_ROW) * NCOLS + int'(WR_COL));
    t_rd   = '0;
    if (rd_ok) begin
      t_rd = tbl[rd_idx];
    end
    acc_d = (CLR_ACC ? '0 : acc_q) + A + B;
  end

  // Lookup is combinational off the old contents, so a same-cycle
  // write lands after the operand has already sampled its entry.
  always_ff @(posedge CLK) begin
    if (state_q == S_INIT) begin
      tbl[cnt_q] <= NBITS'(INIT_BASE + int'(cnt_q) * INIT_STEP);
    end else if (WR_EN && wr_ok) begin
      tbl[wr_idx] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      rdy_q   <= 1'b0;
      acc_q   <= NBITS'(ACC_INIT);
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      t1_q    <= '0;
      n1_q    <= '0;
      v2_q    <= 1'b0;
      diff2_q <= '0;
      prod2_q <= '0;
      ov_q    <= 1'b0;
      x_q     <= '0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= S_RUN;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        S_RUN: begin
        end
        default: begin
        end
      endcase

      v1_q <= acc_en;
      if (acc_en) begin
        acc_q <= acc_d;
        a1_q  <= A;
        b1_q  <= B;
        t1_q  <= t_rd;
        n1_q  <= acc_d;
      end

      v2_q <= v1_q;
      if (v1_q) begin
        diff2_q <= a1_q - KB * b1_q;
        prod2_q <= n1_q * t1_q;
      end

      ov_q <= v2_q;
      if (v2_q) begin
        x_q <= diff2_q - prod2_q;
      end
    end
  end

  assign IN_READY  = rdy_q;
  assign OUT_VALID = ov_q;
  assign XOUT      = x_q;
  assign ACC       = acc_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_init_table_mac.sv
// tb_init_table_mac: directed stimulus, per-cycle compare against a
// behavioural table/accumulator model, plus literal spot checks.
module tb_init_table_mac;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       WR_EN = 1'b0;
  logic [1:0] WR_ROW = '0;
  logic [1:0] WR_COL = '0;
  logic [7:0] WR_DATA = '0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [1:0] ROW = '0;
  logic [1:0] COL = '0;
  logic       CLR_ACC = 1'b0;
  logic       OUT_VALID;
  logic [7:0] XOUT;
  logic [7:0] ACC;
  logic       BUSY;

  always #5 CLK = ~CLK;

  init_table_mac dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .WR_EN    (WR_EN),
    .WR_ROW   (WR_ROW),
    .WR_COL   (WR_COL),
    .WR_DATA  (WR_DATA),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .A        (A),
    .B        (B),
    .ROW      (ROW),
    .COL      (COL),
    .CLR_ACC  (CLR_ACC),
    .OUT_VALID(OUT_VALID),
    .XOUT     (XOUT),
    .ACC      (ACC),
    .BUSY     (BUSY)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, got, exp, $time);
    end
  endtask

  typedef struct {
    int due;
    int x;
  } res_t;

  res_t q[$];
  int   mt[16];
  int   m_acc = 21;
  int   icnt = 0;
  int   ecnt = 0;
  int   m_t, m_n, m_a, m_b, m_x;

  // Model: table filled with 4r+c after reset, then accumulate and
  // schedule each result two edges after its accept edge.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_acc = 21;
      icnt  = 0;
      q.delete();
    end else begin
      ecnt++;
      if (icnt < 16) begin
        mt[icnt] = icnt;
        icnt++;
      end else begin
        if (IN_VALID) begin
          m_a = int'(A);
          m_b = int'(B);
          m_t = mt[int'(ROW) * 4 + int'(COL)];
          m_n = ((CLR_ACC ? 0 : m_acc) + m_a + m_b) % 256;
          m_acc = m_n;
          m_x = ((m_a - 3 * m_b - m_n * m_t) % 256 + 256) % 256;
          q.push_back('{ecnt + 2, m_x});
        end
        if (WR_EN) begin
          mt[int'(WR_ROW) * 4 + int'(WR_COL)] = int'(WR_DATA);
        end
      end
    end
  end

  int   x_hold = 0;
  bit   ov_e;
  res_t r_pop;

  always @(negedge CLK) begin
    if (!RST_N) begin
      x_hold = 0;
    end else begin
      ov_e = (q.size() > 0) && (q[0].due == ecnt);
      if (ov_e) begin
        r_pop  = q.pop_front();
        x_hold = r_pop.x;
      end
      chk("busy", int'(BUSY), int'(icnt < 16));
      chk("in_ready", int'(IN_READY), int'(icnt >= 16));
      chk("acc", int'(ACC), m_acc);
      chk("out_valid", int'(OUT_VALID), int'(ov_e));
      chk("xout", int'(XOUT), x_hold);
    end
  end

  task automatic drive(input bit v, input int a, input int b,
                       input int r, input int c, input bit clr,
                       input bit we, input int wr, input int wc,
                       input int wd);
    IN_VALID = v;
    A        = 8'(a);
    B        = 8'(b);
    ROW      = 2'(r);
    COL      = 2'(c);
    CLR_ACC  = clr;
    WR_EN    = we;
    WR_ROW   = 2'(wr);
    WR_COL   = 2'(wc);
    WR_DATA  = 8'(wd);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (BUSY) n++;
      else break;
    end
  endtask

  task automatic do_reset();
    #2 RST_N = 1'b0;
    @(negedge CLK);
    @(posedge CLK);
    #2 RST_N = 1'b1;
  endtask

  int n;
  int oa[5]   = '{10, 1, 5, 5, 200};
  int ob[5]   = '{2, 1, 0, 0, 100};
  int orw[5]  = '{1, 1, 1, 1, 0};
  int ocl[5]  = '{2, 2, 2, 2, 0};
  bit oclr[5] = '{0, 0, 0, 0, 1};
  bit owe[5]  = '{0, 0, 1, 0, 0};
  int eacc[5] = '{33, 35, 40, 45, 44};
  int ex[5]   = '{62, 44, 21, 5, 156};

  initial begin
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    repeat (4) @(posedge CLK);
    #3 RST_N = 1'b0;
    @(negedge CLK);
    chk("busy_in_rst", int'(BUSY), 1);
    chk("ready_in_rst", int'(IN_READY), 0);
    @(posedge CLK);
    #2 RST_N = 1'b1;
    count_busy(n);
    chk("init_cycles", n, 16);
    chk("ready_after_init", int'(IN_READY), 1);
    chk("acc_reset", int'(ACC), 21);
    chk("xout_reset", int'(XOUT), 0);
    chk("ov_reset", int'(OUT_VALID), 0);

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, oa[i], ob[i], orw[i], ocl[i], oclr[i], owe[i], 1, 2, 0);
      chk($sformatf("acc_op%0d", i), int'(ACC), eacc[i]);
      if (i >= 2) begin
        chk($sformatf("xout_op%0d", i - 2), int'(XOUT), ex[i - 2]);
        chk($sformatf("ov_op%0d", i - 2), int'(OUT_VALID), 1);
      end
    end
    for (int j = 3; j < 5; j++) begin
      idle();
      chk($sformatf("xout_op%0d", j), int'(XOUT), ex[j]);
      chk($sformatf("ov_op%0d", j), int'(OUT_VALID), 1);
    end
    idle();
    chk("ov_gap", int'(OUT_VALID), 0);
    chk("xout_hold", int'(XOUT), 156);

    do_reset();
    count_busy(n);
    chk("init_cycles_2", n, 16);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        drive(1'b1, 1, 0, r, c, 1'b1, 1'b0, 0, 0, 0);
      end
    end
    idle();
    idle();
    chk("readback_t33", int'(XOUT), 242);
    chk("readback_ov", int'(OUT_VALID), 1);
    chk("readback_acc", int'(ACC), 1);

    drive(1'b1, 7, 7, 2, 1, 1'b0, 1'b0, 0, 0, 0);
    idle();
    #2 RST_N = 1'b0;
    @(negedge CLK);
    chk("drop_ov", int'(OUT_VALID), 0);
    chk("drop_acc", int'(ACC), 21);
    @(posedge CLK);
    #2 RST_N = 1'b1;
    count_busy(n);
    chk("init_cycles_3", n, 16);
    chk("acc_after_drop", int'(ACC), 21);
    chk("ov_after_drop", int'(OUT_VALID), 0);
    repeat (4) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
